// File: rtl/periph_mutex_n.sv
// N-node priority/round-robin mutex for a shared byte peripheral, with IRQ lock path and idle watchdog.
// Grant and data outputs are registered (1-cycle latency); no backpressure, every input is sampled each cycle.
module periph_mutex_n #(
  parameter int         NODES       = 4,
  parameter int         DATA_W      = 8,
  parameter logic [3:0] TAG         = 4'b1011,
  parameter logic [7:0] IRQ_CODE    = 8'd78,
  parameter int         TIMEOUT_CYC = 1024,
  localparam int        NW          = $clog2(NODES)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [16*NODES-1:0] in_op,
  input  logic [DATA_W-1:0]   in_peripheral,
  input  logic                in_irq_req,
  input  logic [NW-1:0]       in_irq_node,
  output logic [DATA_W-1:0]   out_peripheral,
  output logic [15:0]         out_node,
  output logic                bus_active,
  output logic [NW-1:0]       owner,
  output logic                locked,
  output logic [NODES-1:0]    out_irq,
  output logic                timeout_pulse
);

  localparam int             WDW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WDW-1:0] WD_LAST   = WDW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [NW-1:0]  LAST_NODE = NW'(NODES - 1);
  localparam logic [NW:0]    NODES_LIM = (NW + 1)'(NODES);

  typedef enum logic {S_IDLE, S_OWNED} state_t;

  state_t            r_state, w_state;
  logic [NW-1:0]     r_owner, w_owner;
  logic [NW-1:0]     r_rr, w_rr;
  logic [WDW-1:0]    r_wd, w_wd;
  logic [DATA_W-1:0] r_operi, w_operi;
  logic [15:0]       r_onode, w_onode;
  logic [NODES-1:0]  r_oirq, w_oirq;
  logic              r_tmo, w_tmo;

  logic [15:0]       w_word, w_cand;
  logic [3:0]        w_best;
  logic [NW-1:0]     w_win;
  logic              w_any, w_release;

  function automatic logic f_is_start(input logic [15:0] w);
    return (w[15:12] == 4'hF) && (w[11:8] == TAG) && (w[7:4] == 4'h0) && (w[3:0] != 4'h0);
  endfunction

  function automatic logic f_is_stop(input logic [15:0] w);
    return w == {4'hF, TAG, 8'hFF};
  endfunction

  // Scan from rr upward; strict '>' keeps the first index holding the maximum priority.
  always_comb begin
    int idx;
    w_any  = 1'b0;
    w_win  = '0;
    w_best = 4'h0;
    w_cand = '0;
    idx    = 0;
    for (int i = 0; i < NODES; i++) begin
      idx = int'(r_rr) + i;
      if (idx >= NODES) idx = idx - NODES;
      w_cand = in_op[16*idx +: 16];
      if (f_is_start(w_cand) && (w_cand[3:0] > w_best)) begin
        w_best = w_cand[3:0];
        w_win  = NW'(idx);
        w_any  = 1'b1;
      end
    end
  end

  always_comb begin
    w_word    = in_op[16*r_owner +: 16];
    w_state   = r_state;
    w_owner   = r_owner;
    w_rr      = r_rr;
    w_wd      = r_wd;
    w_operi   = r_operi;
    w_onode   = r_onode;
    w_oirq    = '0;
    w_tmo     = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_operi = '0;
        w_onode = '0;
        if (in_irq_req && ({1'b0, in_irq_node} < NODES_LIM)) begin
          w_state = S_OWNED;
          w_owner = in_irq_node;
          w_wd    = '0;
        end else if (w_any) begin
          w_state = S_OWNED;
          w_owner = w_win;
          w_wd    = '0;
        end
      end
      S_OWNED: begin
        if (w_word == 16'h0000) begin
          if ((TIMEOUT_CYC != 0) && (r_wd == WD_LAST)) begin
            w_release = 1'b1;
            w_tmo     = 1'b1;
          end else if (r_wd != '1) begin
            w_wd = r_wd + 1'b1;
          end
        end else if (f_is_stop(w_word)) begin
          w_release = 1'b1;
        end else if (f_is_start(w_word)) begin
          w_operi = '0;
          w_onode = '0;
          w_wd    = '0;
        end else begin
          w_operi         = w_word[DATA_W-1:0];
          w_onode         = {8'(r_owner) + 8'd1, 8'(in_peripheral)};
          w_oirq[r_owner] = (8'(in_peripheral) == IRQ_CODE);
          w_wd            = '0;
        end
        if (w_release) begin
          w_state = S_IDLE;
          w_owner = '0;
          w_rr    = (r_owner == LAST_NODE) ? '0 : r_owner + 1'b1;
          w_operi = '0;
          w_onode = '0;
          w_wd    = '0;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_rr    <= '0;
      r_wd    <= '0;
      r_operi <= '0;
      r_onode <= '0;
      r_oirq  <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_owner <= w_owner;
      r_rr    <= w_rr;
      r_wd    <= w_wd;
      r_operi <= w_operi;
      r_onode <= w_onode;
      r_oirq  <= w_oirq;
      r_tmo   <= w_tmo;
    end
  end

  assign out_peripheral = r_operi;
  assign out_node       = r_onode;
  assign bus_active     = (r_state == S_OWNED);
  assign locked         = (r_state == S_OWNED);
  assign owner          = r_owner;
  assign out_irq        = r_oirq;
  assign timeout_pulse  = r_tmo;

endmodule
